// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
//   Shared definitions for the datamemory port arbiter: default bus widths,
//   the arbiter state encoding, the in-flight access tag, and a helper that
//   sizes requester id fields.
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

  localparam int AW_DEF   = 12;  // memory address width
  localparam int MW_DEF   = 12;  // memory read-data width
  localparam int N_DEF    = 17;  // bus / write-data width
  localparam int ID_MAX_W = 3;   // id width that covers up to 8 requesters

  // ARB: round-robin among all requesters. LOCKED: only the owner is served.
  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // One entry of the response pipeline that follows each access to memory.
  typedef struct packed {
    logic                vld;  // an access was issued in this slot
    logic                rd;   // the access was a read (expects a response)
    logic [ID_MAX_W-1:0] id;   // requester that owns the access
  } tag_t;

  // Width of an encoded requester index; never zero, even for one requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_rr_arbiter
//   Combinational round-robin picker. Grants the first requester that is both
//   requesting and enabled by the mask, searching upward from the pointer and
//   wrapping from NREQ-1 back to 0.
// Ports
//   i_req   in  NREQ  request vector
//   i_mask  in  NREQ  eligibility mask (all ones when arbitrating freely)
//   i_ptr   in  IDW   highest-priority requester this cycle
//   o_gnt   out NREQ  one-hot grant (zero when nothing is eligible)
//   o_id    out IDW   encoded index of the granted requester
// -----------------------------------------------------------------------------
module dmem_port_arbiter_rr_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_mask,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_id
);

  logic [NREQ-1:0] w_elig;
  logic [IDW-1:0]  w_idx;
  logic            w_found;

  assign w_elig = i_req & i_mask;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    o_gnt   = '0;
    o_id    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(i_ptr) + i) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Sole driver of the single-port datamemory, shared by NREQ requesters.
//   Round-robin arbitration, one access per cycle, in-order two-stage pipeline.
//   A requester that sets lock on a granted access keeps exclusive ownership
//   until it is granted an access with lock clear.
// Ports
//   clk            in   1        single clock, shared with the memory
//   rst_n          in   1        synchronous active-low reset
//   i_req          in   NREQ     request per requester, held until granted
//   i_req_we       in   NREQ     1 = write, 0 = read
//   i_req_lock     in   NREQ     keep ownership after this access
//   i_req_addr     in   NREQ*AW  packed, requester k at [k*AW +: AW]
//   i_req_wdata    in   NREQ*N   packed, requester k at [k*N +: N]
//   o_gnt          out  NREQ     one-hot, combinational; transfer at this edge
//   o_rvalid       out  NREQ     one-hot; read response for requester k
//   o_rdata        out  MW       read data broadcast, qualified by o_rvalid
//   o_mem_write_en out  1        registered memory write enable
//   o_mem_addr     out  AW       registered memory address
//   o_mem_datain   out  N        registered memory write data (full width)
//   i_mem_dataout  in   MW       memory read data
// Timing: grant in cycle T -> memory port registered at end of T -> memory
// acts at end of T+1 -> read response visible during T+2.
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N    = N_DEF,
  parameter int AW   = AW_DEF,
  parameter int MW   = MW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ-1:0]   i_req_we,
  input  logic [NREQ-1:0]   i_req_lock,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*N-1:0] i_req_wdata,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_rvalid,
  output logic [MW-1:0]     o_rdata,
  output logic              o_mem_write_en,
  output logic [AW-1:0]     o_mem_addr,
  output logic [N-1:0]      o_mem_datain,
  input  logic [MW-1:0]     i_mem_dataout
);

  localparam int IDW = id_width(NREQ);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_owner;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_gnt_raw;
  logic [IDW-1:0]  w_id;
  logic            w_fire;
  logic [IDW-1:0]  w_ptr_nxt;
  tag_t            r_tag1;
  tag_t            r_tag2;

  // While locked, only the owner is eligible.
  always_comb begin
    w_mask = '1;
    if (r_state == ST_LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  dmem_port_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req  (i_req),
    .i_mask (w_mask),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt_raw),
    .o_id   (w_id)
  );

  // Grants are suppressed during reset so no requester sees a phantom transfer.
  assign o_gnt  = rst_n ? w_gnt_raw : '0;
  assign w_fire = |o_gnt;

  assign w_ptr_nxt = (w_id == IDW'(NREQ - 1)) ? '0 : w_id + 1'b1;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:    if (w_fire && i_req_lock[w_id])  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_fire && !i_req_lock[w_id]) w_state_nxt = ST_ARB;
      default:   w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  // The pointer only moves on free arbitration; a locked burst leaves it as
  // it was after the grant that took the lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_owner <= '0;
    end else if (w_fire && r_state == ST_ARB) begin
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_id;
    end
  end

  // ---------------------------------------------------------- memory port
  // Address and data hold their last value on idle cycles; only the write
  // enable drops, so the memory harmlessly re-reads the held address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_mem_write_en <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_datain   <= '0;
    end else if (w_fire) begin
      o_mem_write_en <= i_req_we[w_id];
      o_mem_addr     <= i_req_addr[w_id*AW +: AW];
      o_mem_datain   <= i_req_wdata[w_id*N +: N];
    end else begin
      o_mem_write_en <= 1'b0;
    end
  end

  // ----------------------------------------------------------- tag pipeline
  // NOTE: the tags are reset because they qualify o_rvalid; the memory array
  // itself lives outside and is never reset. A write already registered when
  // reset arrives still lands, its tag is simply discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1 <= '{vld: w_fire, rd: !i_req_we[w_id], id: ID_MAX_W'(w_id)};
      r_tag2 <= r_tag1;
    end
  end

  assign o_rvalid = (r_tag2.vld && r_tag2.rd) ? (NREQ'(1) << r_tag2.id) : '0;
  assign o_rdata  = i_mem_dataout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Drives the arbiter with directed scenarios and randomized traffic and
//   compares every cycle against a transaction-level reference: a priority
//   search for the grant, a flat memory image updated in grant order, and a
//   queue of expected read responses due two cycles after their grant.
//   A behavioural datamemory (12-bit storage, registered read) is attached.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 17;
  localparam int AW   = 12;
  localparam int MW   = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_we = '0;
  logic [NREQ-1:0]   req_lock = '0;
  logic [AW-1:0]     a_addr [NREQ];
  logic [N-1:0]      a_wdata [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*N-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [MW-1:0]     rdata;
  logic              mem_write_en;
  logic [AW-1:0]     mem_addr;
  logic [N-1:0]      mem_datain;
  logic [MW-1:0]     mem_dataout;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*AW +: AW] = a_addr[k];
      req_wdata[k*N +: N]  = a_wdata[k];
    end
  end

  dmem_port_arbiter #(.NREQ(NREQ), .N(N), .AW(AW), .MW(MW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (req),
    .i_req_we       (req_we),
    .i_req_lock     (req_lock),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_gnt          (gnt),
    .o_rvalid       (rvalid),
    .o_rdata        (rdata),
    .o_mem_write_en (mem_write_en),
    .o_mem_addr     (mem_addr),
    .o_mem_datain   (mem_datain),
    .i_mem_dataout  (mem_dataout)
  );

  // Behavioural datamemory: stores datain[11:0], registered read port.
  logic [MW-1:0] mem [4096];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_datain[11:0];
    mem_dataout <= mem[mem_addr];
  end

  initial forever #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  typedef struct {
    int          due;
    int          id;
    logic [11:0] data;
  } rsp_t;

  logic [11:0] ref_mem [4096];
  rsp_t        rq [$];
  int          p      = 0;   // round-robin pointer
  int          owner  = -1;  // lock owner, -1 when arbitrating freely
  int          cyc    = 0;
  int          last_g = -1;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick();
    if (!rst_n) return -1;
    if (owner >= 0) return req[owner] ? owner : -1;
    for (int i = 0; i < NREQ; i++)
      if (req[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, then
  // retire the granted request just after the rising edge.
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_rv;
    logic [11:0]     exp_rd;
    bit              have;
    rsp_t            r;
    @(negedge clk);
    g = pick();
    check("gnt", 32'(gnt), (g < 0) ? 0 : (1 << g));
    exp_rv = '0;
    exp_rd = '0;
    have   = 1'b0;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      exp_rv[r.id] = 1'b1;
      exp_rd       = r.data;
      have         = 1'b1;
    end
    check("rvalid", 32'(rvalid), 32'(exp_rv));
    if (have) check("rdata", 32'(rdata), 32'(exp_rd));
    if (!rst_n) begin
      p     = 0;
      owner = -1;
      rq.delete();
    end else if (g >= 0) begin
      if (req_we[g]) ref_mem[a_addr[g]] = a_wdata[g][11:0];
      else           rq.push_back('{due: cyc + 2, id: g, data: ref_mem[a_addr[g]]});
      if (owner < 0) begin
        p = (g + 1) % NREQ;
        if (req_lock[g]) owner = g;
      end else if (!req_lock[g]) begin
        owner = -1;
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) req[g] = 1'b0;
  endtask

  task automatic set_req(input int k, input bit we, input bit lk, input int ad, input int wd);
    req[k]      = 1'b1;
    req_we[k]   = we;
    req_lock[k] = lk;
    a_addr[k]   = AW'(ad);
    a_wdata[k]  = N'(wd);
  endtask

  task automatic pulse_reset();
    req   = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      a_addr[k]  = '0;
      a_wdata[k] = '0;
    end

    // 1: reset held with every requester asking
    rst_n = 1'b0;
    req   = '1;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_we", 32'(mem_write_en), 0);
    end
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_din", 32'(mem_datain), 0);
    req   = '0;
    rst_n = 1'b1;

    // 2: single write then read-back by requester 0
    set_req(0, 1'b1, 1'b0, 4, 'h0_0ABC);
    step();
    check("t2_wr_gnt", 32'(last_g), 0);
    set_req(0, 1'b0, 1'b0, 4, 0);
    step();
    check("t2_rd_gnt", 32'(last_g), 0);
    step();
    check("t2_rvalid", 32'(rvalid), 32'h1);
    check("t2_rdata", 32'(rdata), 32'hABC);
    step();

    // 3: fairness with all four requesters continuously asking
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NREQ; k++)
        if (!req[k]) set_req(k, 1'b0, 1'b0, (k == 2) ? 4 : 40 + k, 0);
      step();
      check("t3_order", 32'(last_g), 32'(i % NREQ));
    end
    req = '0;
    step();
    step();

    // 4: requester 1 locks for a three-access burst, 0 and 2 waiting
    pulse_reset();
    set_req(0, 1'b0, 1'b0, 1, 0);
    step();
    check("t4_pre", 32'(last_g), 0);
    set_req(0, 1'b0, 1'b0, 2, 0);
    set_req(2, 1'b0, 1'b0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1'b1, (i < 2), 10 + i, 'h100 + i);
      step();
      check("t4_lock", 32'(last_g), 1);
    end
    step();
    check("t4_after", 32'(last_g), 2);
    step();
    check("t4_next", 32'(last_g), 0);
    req = '0;
    step();
    step();

    // 5: write then immediate read of the same address
    set_req(2, 1'b1, 1'b0, 66, 'h055);
    step();
    check("t5_wr", 32'(last_g), 2);
    set_req(3, 1'b0, 1'b0, 66, 0);
    step();
    check("t5_rd", 32'(last_g), 3);
    step();
    check("t5_rvalid", 32'(rvalid), 32'h8);
    check("t5_rdata", 32'(rdata), 32'h055);
    step();

    // 6: reset while a read is in flight
    set_req(1, 1'b0, 1'b0, 4, 0);
    step();
    check("t6_rd", 32'(last_g), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t6_drop", 32'(rvalid[1]), 0);
      step();
    end
    req = '1;
    req_we = '0;
    req_lock = '0;
    step();
    check("t6_restart", 32'(last_g), 0);
    req = '0;
    step();
    step();

    // Randomized traffic: new requests, locks, withdrawals and rare resets
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 15)), int'($urandom));
        end else if ($urandom_range(0, 31) == 0) begin
          req[k] = 1'b0;
        end
      end
      step();
    end
    rst_n = 1'b1;
    req   = '0;
    for (int i = 0; i < 4; i++) step();
    check("drain", 32'(rq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
